// File: rtl/alu_issue_ctrl.sv
// Purpose: register-file front end that feeds the 8-bit ALU and writes its result back.
// Latency: accept on edge T, ALU settles at T+1, writeback and flag capture on the closing edge of T+2.
// Backpressure: instr_ready is low in EXEC and WB, so one instruction is accepted every 3 cycles.
module alu_issue_ctrl #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [9:0]        instr,
    input  logic              ld_en,
    input  logic [1:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [1:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_ov,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_ov,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    // Highest defined opcode (DEC B); everything above it is illegal.
    localparam logic [3:0] OP_LAST = 4'd8;

    logic [1:0]        state;
    logic [1:0]        dst_q;
    logic [DATA_W-1:0] regs [REG_CNT];
    logic              accept;
    logic              in_wb;
    logic              op_legal;

    assign instr_ready = (state == S_IDLE);
    assign accept      = instr_valid && instr_ready;
    assign in_wb       = (state == S_WB);
    assign done        = in_wb;
    // alu_op is held from accept, so legality is judged on the latched opcode.
    assign op_legal    = (alu_op <= OP_LAST);
    assign rd_data     = regs[rd_addr];

    // Sequence each instruction through EXEC and WB before offering ready again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state <= accept ? S_EXEC : S_IDLE;
                S_EXEC:  state <= S_WB;
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture operands, opcode and destination on accept; they stay put until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            dst_q  <= '0;
        end else if (accept) begin
            alu_a  <= regs[instr[3:2]];
            alu_b  <= regs[instr[1:0]];
            alu_op <= instr[9:6];
            dst_q  <= instr[5:4];
        end
    end

    // Register file: direct loads at any time; a legal writeback to the same register overrides the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            if (in_wb && op_legal) begin
                regs[dst_q] <= alu_result;
            end
        end
    end

    // Flags follow the ALU on legal writebacks; err latches illegal ops until the next legal one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_ov <= 1'b0;
            err     <= 1'b0;
        end else if (in_wb) begin
            if (op_legal) begin
                flag_c  <= alu_c;
                flag_z  <= alu_z;
                flag_n  <= alu_n;
                flag_ov <= alu_ov;
                err     <= 1'b0;
            end else begin
                err     <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential front end for the 8-bit gate-level ALU. It owns a small register file and accepts instructions over a valid/ready handshake.
- Per instruction it drives the ALU operand and op-select inputs from the register file, then captures the ALU result and C/Z/N/OV flags.
- The result is written back to a destination register. The block sits directly upstream of the ALU and also consumes its outputs, so it closes the datapath loop.

Parameters:
- DATA_W, 8, operand/result width; must equal the ALU width; only 8 is supported.
- REG_CNT, 4, number of general registers; address width is 2 bits.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- instr_valid  input  1  instruction offered
- instr_ready  output  1  block can accept an instruction
- instr  input  10  [9:6] op_sel, [5:4] dst, [3:2] srcA, [1:0] srcB
- ld_en  input  1  direct register load strobe
- ld_addr  input  2  load target register
- ld_data  input  8  load value
- rd_addr  input  2  debug read address
- rd_data  output  8  combinational read of reg[rd_addr]
- alu_a  output  8  to ALU A
- alu_b  output  8  to ALU B
- alu_op  output  4  to ALU op_sel
- alu_result  input  8  from ALU result
- alu_c, alu_z, alu_n, alu_ov  input  1 each  from ALU flags
- flag_c, flag_z, flag_n, flag_ov  output  1 each  registered status flags
- done  output  1  one-cycle pulse in the writeback cycle
- err  output  1  registered illegal-op indicator

Behaviour:
- Reset (async, active-high): state=IDLE; all registers 0x00; alu_a, alu_b, alu_op = 0; all flags 0; err=0; done=0. Reset in any state aborts the instruction with no writeback and no flag update.
- Opcodes: 0 ADD A+B, 1 SUB A-B, 2 AND, 3 OR, 4 MOV A, 5 SHL A, 6 SHR A, 7 INC B, 8 DEC B. Opcodes 9–15 are illegal.
- FSM: IDLE -> EXEC -> WB -> IDLE.
- instr_ready = (state==IDLE). An instruction is accepted on the edge where instr_valid && instr_ready.
- Accept edge (T): latch alu_a=reg[srcA], alu_b=reg[srcB], alu_op=op_sel, and dst. Move to EXEC.
- EXEC (T+1): ALU inputs are held stable; the ALU settles combinationally. Move to WB.
- WB (T+2): done=1 (done = state==WB).
  - Legal op: on the closing edge reg[dst] <= alu_result, and flag_c/z/n/ov <= alu_c/z/n/ov; err <= 0.
  - Illegal op: no register write, flags unchanged, err <= 1.
  - Move to IDLE.
- Throughput: one instruction per 3 cycles; instr_ready is low for exactly 2 cycles after each accept.
- alu_a, alu_b and alu_op hold their last values in IDLE; they change only on accept.
- err is sticky until the next legal WB.
- ld_en: reg[ld_addr] <= ld_data on any edge, in any state, except:
  - In WB with ld_addr==dst on a legal op: writeback wins and the load is dropped.
  - In WB with ld_addr!=dst: both writes occur.
- Same-edge accept and load to srcA/srcB: the operand captures the pre-load value; the register holds the new value afterwards.
- rd_data is a combinational read and reflects writes from the following cycle.
- Flags are taken verbatim from the ALU for every legal op, logic/move/shift included; no recomputation in this block.
- Register arithmetic is 8-bit only; wrap-around is the ALU's responsibility.

Test Plan:
- Reset, load R0=0x05, R1=0x03, issue ADD dst=R2 srcA=R0 srcB=R1 -> instr_ready low 2 cycles; done at T+2; R2=0x08; Z=0, N=0, OV=0.
- Load R1=0x03, SUB dst=R3 srcA=R1 srcB=R1 -> R3=0x00, flag_z=1, flag_n=0.
- Load R0=0x7F, R1=0x01, ADD dst=R0 -> R0=0x80, flag_n=1, flag_ov=1, flag_z=0.
- Issue op=0xC after a legal ADD -> err=1, all registers and flags unchanged, done pulses. Next legal MOV -> err=0.
- Assert rst during EXEC of ADD dst=R2 -> R2=0x00, all flags 0, state IDLE; instr_ready=1 on the first clock after rst deasserts.
- Collisions:
  - ld_en ld_addr=dst ld_data=0xAA in the WB cycle -> register holds the ALU result.
  - Same-edge accept with ld_addr=srcA ld_data=0x55 -> operand uses the old value, and the register reads 0x55 afterwards.
